sbox_escalonador: RTL

- Time-shares LANES combinational S-box lookups (sbox module instances) between two requesters: round SubBytes on the 128-bit state, and key-expansion SubWord on a 32-bit word.
- Sits between the round controller / key-expansion unit and the S-box instances.
- Replaces 20 dedicated S-boxes with LANES shared ones.
- Multi-cycle, with round-robin arbitration and a registered result plus done handshake per requester.

---
 rtl/sbox_escalonador_if.sv | 34 +++
 rtl/sbox_escalonador.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sbox_escalonador_if.sv
// ============================================================================
// Module  : sbox_escalonador_if
// Purpose : Request/ack/result bundle between the requesters and the S-box scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sbox_escalonador_if;
  logic         req_estado;
  logic [127:0] estado_in;
  logic         ack_estado;
  logic [127:0] estado_out;
  logic         done_estado;
  logic         req_chave;
  logic [31:0]  palavra_in;
  logic         ack_chave;
  logic [31:0]  palavra_out;
  logic         done_chave;
  logic         ocupado;

  modport master (
    output req_estado, estado_in, req_chave, palavra_in,
    input  ack_estado, estado_out, done_estado,
    input  ack_chave, palavra_out, done_chave, ocupado
  );

  modport slave (
    input  req_estado, estado_in, req_chave, palavra_in,
    output ack_estado, estado_out, done_estado,
    output ack_chave, palavra_out, done_chave, ocupado
  );
endinterface

`default_nettype wire

// File: rtl/sbox_escalonador.sv
// ============================================================================
// Module  : sbox_escalonador (with leaf sbox)
// Purpose : Round-robin time-sharing of LANES AES S-boxes between SubBytes and SubWord.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sbox (
  input  wire  [7:0] a_i,
  output logic [7:0] y_o
);
  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y_o = TBL[(255 - int'(a_i)) * 8 +: 8];
endmodule

module sbox_escalonador #(
  parameter int LANES = 4
) (
  input wire               clk,
  input wire               rst,
  sbox_escalonador_if.slave bus
);
  localparam int   N_E        = 16 / LANES;
  localparam int   N_P        = 4 / LANES;
  localparam int   CNT_W      = $clog2(N_E);
  localparam logic ULT_ESTADO = 1'b1;

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    SUB_ESTADO  = 2'd1,
    SUB_PALAVRA = 2'd2
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ultimo_q, ultimo_d;
  logic [127:0]     work_q, work_d;
  logic [127:0]     res_q, res_d;
  logic [127:0]     est_out_q, est_out_d;
  logic [31:0]      pal_out_q, pal_out_d;
  logic             done_e_q, done_e_d;
  logic             done_c_q, done_c_d;
  logic             w_ack_e, w_ack_c;

  logic [3:0] w_idx    [LANES];
  logic [7:0] w_sb_in  [LANES];
  logic [7:0] w_sb_out [LANES];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign w_idx[j]   = 4'(int'(cnt_q) * LANES + j);
    assign w_sb_in[j] = work_q[{w_idx[j], 3'b000} +: 8];
    sbox u_sbox (.a_i(w_sb_in[j]), .y_o(w_sb_out[j]));
  end

  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    ultimo_d  = ultimo_q;
    work_d    = work_q;
    res_d     = res_q;
    est_out_d = est_out_q;
    pal_out_d = pal_out_q;
    done_e_d  = 1'b0;
    done_c_d  = 1'b0;
    w_ack_e   = 1'b0;
    w_ack_c   = 1'b0;

    if (fsm_q != OCIOSO) begin
      for (int j = 0; j < LANES; j++) begin
        res_d[{w_idx[j], 3'b000} +: 8] = w_sb_out[j];
      end
    end

    case (fsm_q)
      OCIOSO: begin
        // On a tie the requester that was not served last wins.
        if (bus.req_estado && (!bus.req_chave || (ultimo_q != ULT_ESTADO))) begin
          w_ack_e  = 1'b1;
          work_d   = bus.estado_in;
          ultimo_d = ULT_ESTADO;
          cnt_d    = '0;
          fsm_d    = SUB_ESTADO;
        end else if (bus.req_chave) begin
          w_ack_c  = 1'b1;
          work_d   = {96'd0, bus.palavra_in};
          ultimo_d = ~ULT_ESTADO;
          cnt_d    = '0;
          fsm_d    = SUB_PALAVRA;
        end
      end
      SUB_ESTADO: begin
        if (cnt_q == CNT_W'(N_E - 1)) begin
          est_out_d = res_d;
          done_e_d  = 1'b1;
          fsm_d     = OCIOSO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SUB_PALAVRA: begin
        if (cnt_q == CNT_W'(N_P - 1)) begin
          pal_out_d = res_d[31:0];
          done_c_d  = 1'b1;
          fsm_d     = OCIOSO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: fsm_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= OCIOSO;
      cnt_q     <= '0;
      ultimo_q  <= ULT_ESTADO;
      work_q    <= '0;
      res_q     <= '0;
      est_out_q <= '0;
      pal_out_q <= '0;
      done_e_q  <= 1'b0;
      done_c_q  <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      ultimo_q  <= ultimo_d;
      work_q    <= work_d;
      res_q     <= res_d;
      est_out_q <= est_out_d;
      pal_out_q <= pal_out_d;
      done_e_q  <= done_e_d;
      done_c_q  <= done_c_d;
    end
  end

  // Acks are combinational, so they must be masked while reset is held.
  assign bus.ack_estado  = w_ack_e & ~rst;
  assign bus.ack_chave   = w_ack_c & ~rst;
  assign bus.estado_out  = est_out_q;
  assign bus.palavra_out = pal_out_q;
  assign bus.done_estado = done_e_q;
  assign bus.done_chave  = done_c_q;
  assign bus.ocupado     = (fsm_q != OCIOSO);
endmodule

`default_nettype wire
